// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// State encodings double as the LED code driven on estado.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_AND) ||
               (op == OP_SUB) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_edge_detect.sv
// Rising-edge pulse generator for a debounced button level.
// The pulse is high for the single cycle in which the level first reads high.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: captures A, B and opcode from data_in on enter presses,
// runs one ALU cycle and shows the result. Define ALU_CHAIN_EN for accumulator chaining.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int largo = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [largo-1:0] data_in,
    input  logic             enter,
    input  logic             undo,
    output logic [largo-1:0] alu_a,
    output logic [largo-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [largo-1:0] alu_result,
    output logic [largo-1:0] result,
    output logic [largo-1:0] display,
    output logic [2:0]       estado,
    output logic             error,
    output logic             done
);

    logic enter_p;
    logic undo_p;

    edge_detect u_enter_edge (
        .clk     (clk),
        .reset   (reset),
        .level_i (enter),
        .pulse_o (enter_p)
    );

    edge_detect u_undo_edge (
        .clk     (clk),
        .reset   (reset),
        .level_i (undo),
        .pulse_o (undo_p)
    );

    state_t           state_q;
    logic [largo-1:0] alu_a_q;
    logic [largo-1:0] alu_b_q;
    logic [2:0]       alu_op_q;
    logic [largo-1:0] result_q;
    logic             error_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_A;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    if (enter_p) begin
                        alu_a_q <= data_in;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (undo_p) begin
                        state_q <= WAIT_A;
                    end else if (enter_p) begin
                        alu_b_q <= data_in;
                        state_q <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (undo_p) begin
                        state_q <= WAIT_B;
                    end else if (enter_p) begin
                        alu_op_q <= data_in[2:0];
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    // Unused opcodes are forced to zero regardless of what the ALU drives.
                    result_q <= is_valid_op(alu_op_q) ? alu_result : '0;
                    error_q  <= ~is_valid_op(alu_op_q);
                    done_q   <= 1'b1;
                    state_q  <= SHOW;
                end
                SHOW: begin
                    if (undo_p) begin
                        error_q <= 1'b0;
                        state_q <= WAIT_OP;
                    end else if (enter_p) begin
                        error_q <= 1'b0;
`ifdef ALU_CHAIN_EN
                        alu_a_q <= result_q;
                        state_q <= WAIT_B;
`else
                        state_q <= WAIT_A;
`endif
                    end
                end
                default: begin
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign result  = result_q;
    assign error   = error_q;
    assign done    = done_q;
    assign estado  = state_q;
    assign display = (state_q == SHOW) ? result_q : data_in;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed test-plan steps plus random button presses,
// checked against a press-level model. Define ALU_CHAIN_EN to check chaining.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        enter;
    logic        undo;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic [15:0] result;
    logic [15:0] display;
    logic [2:0]  estado;
    logic        error;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl #(.largo(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .enter      (enter),
        .undo       (undo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .result     (result),
        .display    (display),
        .estado     (estado),
        .error      (error),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU; unused opcodes drive junk so the controller's zeroing is visible.
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
        logic [31:0] prod;
        prod = a * b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return prod[15:0];
            3'd2:    return {15'd0, (a != 0) && (b != 0)};
            3'd4:    return a - b;
            3'd5:    return {15'd0, (a != 0) || (b != 0)};
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    // Model: stage 0..4 = A, B, OP, EXEC, SHOW
    int          m_st;
    logic [15:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    logic        m_err;

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
    endtask

    task automatic model_press(input logic e, input logic u, input logic [15:0] d);
        if (u && m_st != 0) begin
            if (m_st == 4) m_err = 0;
            m_st = (m_st == 4) ? 2 : m_st - 1;
        end else if (e) begin
            if (m_st == 0) begin m_a = d; m_st = 1; end
            else if (m_st == 1) begin m_b = d; m_st = 2; end
            else if (m_st == 2) begin m_op = d[2:0]; m_st = 3; end
            else if (m_st == 4) begin
                m_err = 0;
`ifdef ALU_CHAIN_EN
                m_a = m_res; m_st = 1;
`else
                m_st = 0;
`endif
            end
        end
    endtask

    task automatic model_exec();
        logic valid;
        valid = (m_op == 0) || (m_op == 1) || (m_op == 2) || (m_op == 4) || (m_op == 5);
        m_res = valid ? alu_fn(m_a, m_b, m_op) : 16'h0000;
        m_err = ~valid;
        m_st  = 4;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        chk("estado", {13'd0, estado}, m_st[15:0]);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", {13'd0, alu_op}, {13'd0, m_op});
        chk("result", result, m_res);
        chk("error", {15'd0, error}, {15'd0, m_err});
        chk("done_idle", {15'd0, done}, 16'd0);
        chk("display", display, (m_st == 4) ? m_res : data_in);
    endtask

    // One press: edge on the first tick, released before the next.
    task automatic press(input logic e, input logic u, input logic [15:0] d);
        data_in = d; enter = e; undo = u;
        tick();
        enter = 1'b0; undo = 1'b0;
        model_press(e, u, d);
        if (m_st == 3) begin
            chk("exec_state", {13'd0, estado}, 16'd3);
            chk("exec_done", {15'd0, done}, 16'd0);
            tick();
            model_exec();
            chk("done_pulse", {15'd0, done}, 16'd1);
            chk("exec_result", result, m_res);
            chk("exec_error", {15'd0, error}, {15'd0, m_err});
            tick();
        end else begin
            tick();
        end
        check_all();
    endtask

    task automatic go_wait_a();
        for (int i = 0; i < 6; i++) begin
            if (m_st == 4) press(1'b1, 1'b0, 16'h0000);
            else if (m_st != 0) press(1'b0, 1'b1, 16'h0000);
        end
        chk("reach_wait_a", {13'd0, estado}, 16'd0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        go_wait_a();
        press(1'b1, 1'b0, a);
        press(1'b1, 1'b0, b);
        press(1'b1, 1'b0, {13'd0, op});
    endtask

    initial begin
        logic [15:0] d;
        int r;
        reset = 1'b1; enter = 1'b0; undo = 1'b0; data_in = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        check_all();

        run_op(16'h0005, 16'h0003, 3'd0);
        chk("tp_add", result, 16'h0008);
        chk("tp_add_err", {15'd0, error}, 16'd0);

        run_op(16'h0003, 16'h0005, 3'd4);
        chk("tp_sub", result, 16'hFFFE);
        run_op(16'h0100, 16'h0100, 3'd1);
        chk("tp_mul", result, 16'h0000);

        run_op(16'h1111, 16'h2222, 3'd3);
        chk("tp_bad_res", result, 16'h0000);
        chk("tp_bad_err", {15'd0, error}, 16'd1);
        press(1'b1, 1'b0, 16'h0000);
        chk("tp_err_clear", {15'd0, error}, 16'd0);

        // Held enter advances one stage only.
        go_wait_a();
        data_in = 16'h0ABC; enter = 1'b1;
        repeat (50) tick();
        enter = 1'b0;
        tick();
        model_press(1'b1, 1'b0, 16'h0ABC);
        check_all();
        chk("tp_hold_state", {13'd0, estado}, 16'd1);

        // Simultaneous enter and undo in WAIT_OP: undo wins.
        press(1'b1, 1'b0, 16'h0042);
        press(1'b1, 1'b1, 16'h7777);
        chk("tp_both_state", {13'd0, estado}, 16'd1);
        chk("tp_both_b", alu_b, 16'h0042);

        // Reset mid-entry.
        go_wait_a();
        press(1'b1, 1'b0, 16'h1234);
        press(1'b1, 1'b0, 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_all();
        chk("tp_rst_a", alu_a, 16'h0000);

`ifdef ALU_CHAIN_EN
        run_op(16'h0002, 16'h0003, 3'd0);
        chk("tp_chain_first", display, 16'h0005);
        press(1'b1, 1'b0, 16'hFFFF);
        chk("tp_chain_state", {13'd0, estado}, 16'd1);
        chk("tp_chain_a", alu_a, 16'h0005);
        press(1'b1, 1'b0, 16'h0004);
        press(1'b1, 1'b0, 16'h0000);
        chk("tp_chain_res", result, 16'h0009);
`endif

        for (int i = 0; i < 80; i++) begin
            d = 16'($urandom());
            r = $urandom_range(0, 9);
            if (r < 7) press(1'b1, 1'b0, d);
            else if (r < 9 || m_st == 0) press(1'b0, 1'b1, d);
            else press(1'b1, 1'b1, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller for the team's combinational ALU. It captures operand A, operand B and the opcode from a shared input bus on successive "enter" presses, then applies them to the ALU.
- It registers the ALU result and drives the display/state indicators.
- It sits between the board I/O (switches, buttons) and the ALU instance.

Parameters:
- largo, 16, operand and result width in bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data_in  input  largo  operand/opcode entry bus; opcode is data_in[2:0]
- enter  input  1  level from a debounced button; the controller edge-detects it internally
- undo  input  1  level from a debounced button; steps back one entry stage (edge-detected)
- alu_a  output  largo  registered operand A to the ALU
- alu_b  output  largo  registered operand B to the ALU
- alu_op  output  3  registered opcode to the ALU
- alu_result  input  largo  combinational result from the ALU
- result  output  largo  registered result of the last executed operation
- display  output  largo  value to show: data_in during entry stages, result in SHOW
- estado  output  3  current FSM state encoding, for LEDs
- error  output  1  high while SHOW holds an invalid-opcode result
- done  output  1  one-cycle pulse when result is updated

Behaviour:
- Reset (synchronous, active-high): state=WAIT_A; alu_a, alu_b, result=0; alu_op=0; error=0; done=0; edge-detect registers=0.
- Edge detection: enter_p = enter & ~enter_q. undo_p is formed the same way. Holding a button high advances exactly one stage.
- States and encodings:
  - WAIT_A=0: on enter_p, alu_a<=data_in, go to WAIT_B.
  - WAIT_B=1: on enter_p, alu_b<=data_in, go to WAIT_OP.
  - WAIT_OP=2: on enter_p, alu_op<=data_in[2:0], go to EXEC.
  - EXEC=3: single cycle, no button input sampled. result<=alu_result; error<=(alu_op in {3,6,7}); done=1 in the following cycle; go to SHOW.
  - SHOW=4: on enter_p, go to WAIT_A. Captured registers are kept until overwritten.
- Undo:
  - WAIT_B goes to WAIT_A; WAIT_OP goes to WAIT_B; SHOW goes to WAIT_OP.
  - WAIT_A: undo is ignored.
  - Previously captured values are retained, so the user re-enters only that stage.
- Simultaneous enter_p and undo_p: undo wins; enter is dropped, not queued.
- Opcode map, applied to the ALU:
  - 0 add, 1 multiply (low largo bits), 2 logical AND (0/1), 4 subtract (two's complement wrap), 5 logical OR (0/1).
  - 3, 6, 7 give result 0 with error=1.
- Widths: all arithmetic is truncated to largo bits; no carry/overflow flag is produced.
- Latency: 1 cycle from the WAIT_OP enter edge to EXEC; result is valid and done pulses 2 cycles after that edge.
- Reset mid-operation: immediate return to the reset state; any partially entered operands are discarded.
- error clears on leaving SHOW.

Optional Feature:
- Macro ALU_CHAIN_EN.
- Defined:
  - Enter in SHOW copies result into alu_a and goes to WAIT_B, giving accumulator-style chaining.
  - Undo in SHOW still goes to WAIT_OP.
  - estado and error behave unchanged.
- Undefined: enter in SHOW goes to WAIT_A, as specified above.

Decomposition:
- Package alu_ctrl_pkg holds:
  - typedef enum logic [2:0] state_t {WAIT_A, WAIT_B, WAIT_OP, EXEC, SHOW};
  - opcode constants OP_ADD=0, OP_MUL=1, OP_AND=2, OP_SUB=4, OP_OR=5;
  - function is_valid_op.
- Sub-module edge_detect (rising-edge pulse generator), instantiated twice, for enter and undo.
- The ALU is instantiated in the parent, not inside this block.

Test Plan (largo=16):
- A=0x0005, B=0x0003, op=0 entered via three enter pulses -> result=0x0008, error=0, done high for exactly 1 cycle two cycles after the op edge.
- A=0x0003, B=0x0005, op=4 -> result=0xFFFE. Then A=0x0100, B=0x0100, op=1 -> result=0x0000.
- op=3 with any operands -> result=0x0000, error=1 in SHOW, error=0 after the next enter.
- enter held high for 50 cycles in WAIT_A -> exactly one transition to WAIT_B. enter and undo rising together in WAIT_OP -> state WAIT_B, alu_b unchanged.
- reset asserted in WAIT_OP after A=0x1234, B=0x0001 -> next cycle estado=0, alu_a=alu_b=result=0.
- ALU_CHAIN_EN defined: 2+3 (op 0) gives SHOW 0x0005; enter, B=0x0004, op=0 -> result=0x0009, with no A entry stage.
